// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and the alu datapath width
package alu_pkg;

   localparam int ALU_W = 5;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CAPTURE,
      RESP
   } seq_state_t;

endpackage

// File: rtl/alu_golden_model.sv
// rtl/alu_golden_model.sv - combinational reference result for one alu command
module alu_golden_model
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] expected,
   output logic              check_en
);

   // All arithmetic is evaluated at DATA_W bits, so wrap and low-half multiply fall out naturally
   always_comb begin
      expected = '0;
      check_en = 1'b1;
      case (op)
         OP_ADD:  expected = a + b;
         OP_SUB:  expected = a - b;
         OP_MUL:  expected = a * b;
         default: check_en = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - drives the alu one command at a time, captures and checks its result
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W        = ALU_W,
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [1:0]        cmd_op,
   output logic [DATA_W-1:0] alu_num1,
   output logic [DATA_W-1:0] alu_num2,
   output logic [1:0]        alu_operation,
   input  logic [DATA_W-1:0] alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [1:0]        rsp_op,
   output logic              rsp_mismatch,
   input  logic              err_clr,
   output logic [ERR_W-1:0]  err_count,
   output logic              busy
);

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

   seq_state_t        state, state_nxt;
   logic [3:0]        settle_cnt;
   logic [DATA_W-1:0] gold;
   logic              gold_en;
   logic              mism_now;
   logic              accept;

   assign accept = cmd_valid && cmd_ready;

   // Golden value is taken from the held alu operands, so it lines up with the captured result
   alu_golden_model #(.DATA_W(DATA_W)) u_golden (
      .a        (alu_num1),
      .b        (alu_num2),
      .op       (alu_operation),
      .expected (gold),
      .check_en (gold_en)
   );

   assign mism_now = gold_en && (rsp_result != gold);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         settle_cnt    <= '0;
         alu_num1      <= '0;
         alu_num2      <= '0;
         alu_operation <= '0;
         rsp_result    <= '0;
         rsp_op        <= '0;
         rsp_mismatch  <= 1'b0;
         err_count     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_num1      <= cmd_a;
            alu_num2      <= cmd_b;
            alu_operation <= cmd_op;
            settle_cnt    <= SETTLE_M1;
         end else if (state == DRIVE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
         end
         // alu_out is sampled on the edge that closes the settle window
         if (state == DRIVE && settle_cnt == '0) begin
            rsp_result <= alu_out;
            rsp_op     <= alu_operation;
         end
         if (state == CAPTURE) begin
            rsp_mismatch <= mism_now;
         end
         if (err_clr) begin
            err_count <= '0;
         end else if (state == CAPTURE && mism_now && err_count != '1) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) state_nxt = DRIVE;
         end
         DRIVE: begin
            if (settle_cnt == '0) state_nxt = CAPTURE;
         end
         CAPTURE: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a behavioural alu and model
module tb_alu_cmd_sequencer;

   localparam int S  = 1;
   localparam int S4 = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Primary instance (SETTLE_CYCLES = 1)
   logic       rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b1, err_clr = 1'b0, alu_bad = 1'b0;
   logic [4:0] cmd_a = '0, cmd_b = '0;
   logic [1:0] cmd_op = '0;
   logic       cmd_ready, rsp_valid, rsp_mismatch, busy;
   logic [4:0] alu_num1, alu_num2, alu_out, rsp_result;
   logic [1:0] alu_operation, rsp_op;
   logic [7:0] err_count;

   // Second instance (SETTLE_CYCLES = 4)
   logic       rst4 = 1'b1, v4 = 1'b0, bad4 = 1'b0;
   logic [4:0] a4 = '0, b4 = '0;
   logic [1:0] op4 = '0;
   logic       rdy4, rv4, mis4, busy4;
   logic [4:0] n1_4, n2_4, out4, res4;
   logic [1:0] aop4, rop4;
   logic [7:0] err4;

   function automatic logic [4:0] alu_ref(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a * b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int golden(input int a, input int b, input int op);
      case (op)
         0:       return (a + b) % 32;
         1:       return (a - b + 32) % 32;
         2:       return (a * b) % 32;
         default: return -1;
      endcase
   endfunction

   assign alu_out = alu_bad ? 5'd0 : alu_ref(alu_num1, alu_num2, alu_operation);
   assign out4    = bad4    ? 5'd0 : alu_ref(n1_4, n2_4, aop4);

   alu_cmd_sequencer #(.DATA_W(5), .SETTLE_CYCLES(S), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_operation(alu_operation), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
      .rsp_mismatch(rsp_mismatch), .err_clr(err_clr), .err_count(err_count), .busy(busy)
   );

   alu_cmd_sequencer #(.DATA_W(5), .SETTLE_CYCLES(S4), .ERR_W(8)) u_dut4 (
      .clk(clk), .rst(rst4), .cmd_valid(v4), .cmd_ready(rdy4),
      .cmd_a(a4), .cmd_b(b4), .cmd_op(op4),
      .alu_num1(n1_4), .alu_num2(n2_4), .alu_operation(aop4), .alu_out(out4),
      .rsp_valid(rv4), .rsp_ready(1'b1), .rsp_result(res4), .rsp_op(rop4),
      .rsp_mismatch(mis4), .err_clr(1'b0), .err_count(err4), .busy(busy4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one command in flight, aged in clock edges since its accept edge
   bit         m_busy = 0;
   int         m_age  = 0;
   int         m_err  = 0;
   logic [4:0] m_a = '0, m_b = '0, m_res = '0;
   logic [1:0] m_op = '0;
   bit         m_mis = 0;
   bit         mon_en = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_age <= 0; m_err <= 0;
         m_a <= '0; m_b <= '0; m_op <= '0;
      end else begin
         if (err_clr) m_err <= 0;
         else if (m_busy && m_age == S && m_mis && m_err != 255) m_err <= m_err + 1;
         if (m_busy) begin
            m_age <= m_age + 1;
            if (m_age >= S + 1 && rsp_ready) m_busy <= 0;
         end else if (cmd_valid) begin
            m_busy <= 1; m_age <= 0;
            m_a <= cmd_a; m_b <= cmd_b; m_op <= cmd_op;
            m_res <= alu_bad ? 5'd0 : alu_ref(cmd_a, cmd_b, cmd_op);
            m_mis <= (cmd_op != 2'd3) &&
                     (int'(alu_bad ? 5'd0 : alu_ref(cmd_a, cmd_b, cmd_op)) != golden(int'(cmd_a), int'(cmd_b), int'(cmd_op)));
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_cmd_ready", cmd_ready, !m_busy);
         chk("mon_busy", busy, m_busy);
         chk("mon_rsp_valid", rsp_valid, m_busy && m_age >= S + 1);
         chk("mon_alu_num1", alu_num1, m_a);
         chk("mon_alu_num2", alu_num2, m_b);
         chk("mon_alu_op", alu_operation, m_op);
         chk("mon_err_count", err_count, m_err);
         if (m_busy && m_age >= S + 1) begin
            chk("mon_rsp_result", rsp_result, m_res);
            chk("mon_rsp_op", rsp_op, m_op);
            chk("mon_rsp_mismatch", rsp_mismatch, m_mis);
         end
      end
   end

   // Called at a falling edge with the sequencer idle and rsp_ready high
   task automatic run_cmd(input string name, input logic [4:0] a, input logic [4:0] b, input logic [1:0] op,
                          input int exp_res, input int exp_mis);
      int n;
      chk({name, "_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, n, S + 2);
      chk({name, "_result"}, rsp_result, exp_res);
      chk({name, "_mismatch"}, rsp_mismatch, exp_mis);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0; rst4 = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_op", rsp_op, 0);
      chk("rst_rsp_mismatch", rsp_mismatch, 0);
      chk("rst_alu_ports", {alu_num1, alu_num2, alu_operation}, 0);
      chk("rst_err_count", err_count, 0);
      mon_en = 1;

      run_cmd("add_2_2", 5'd2, 5'd2, 2'd0, 4, 0);
      run_cmd("sub_3_1", 5'd3, 5'd1, 2'd1, 2, 0);
      run_cmd("mul_3_2", 5'd3, 5'd2, 2'd2, 6, 0);
      run_cmd("add_wrap", 5'd31, 5'd1, 2'd0, 0, 0);
      run_cmd("sub_wrap", 5'd1, 5'd3, 2'd1, 30, 0);
      run_cmd("mul_wrap", 5'd7, 5'd6, 2'd2, 10, 0);
      run_cmd("rsvd_op", 5'd5, 5'd9, 2'd3, 12, 0);
      chk("err_after_clean", err_count, 0);

      // Backpressure: response must stay frozen and a waiting command must not be taken
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_a = 5'd10; cmd_b = 5'd5; cmd_op = 2'd1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_latency", n, S + 2);
      cmd_valid = 1'b1; cmd_a = 5'd1; cmd_b = 5'd2; cmd_op = 2'd0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid_held", rsp_valid, 1);
         chk("bp_result_held", rsp_result, 5);
         chk("bp_op_held", rsp_op, 1);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_retire_idle", busy, 0);
      chk("bp_retire_valid", rsp_valid, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_second_taken", busy, 1);
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_second_result", rsp_result, 3);
      @(negedge clk);

      // Fault injection on the alu output
      alu_bad = 1'b1;
      run_cmd("fault_3_4", 5'd3, 5'd4, 2'd0, 0, 1);
      chk("fault_err_one", err_count, 1);
      err_clr = 1'b1;
      run_cmd("fault_clr", 5'd1, 5'd1, 2'd0, 0, 1);
      err_clr = 1'b0;
      chk("clr_wins", err_count, 0);
      run_cmd("fault_rsvd", 5'd5, 5'd9, 2'd3, 0, 0);
      chk("rsvd_not_counted", err_count, 0);
      for (int i = 0; i < 258; i++) run_cmd("sat", 5'd1, 5'd1, 2'd0, 0, 1);
      chk("err_saturated", err_count, 255);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", err_count, 0);
      alu_bad = 1'b0;
      mon_en = 0;

      // SETTLE_CYCLES = 4 instance: latency, fault count, then reset while in DRIVE
      bad4 = 1'b1;
      v4 = 1'b1; a4 = 5'd3; b4 = 5'd4; op4 = 2'd0;
      @(negedge clk);
      v4 = 1'b0;
      n = 1;
      while (!rv4 && n < 30) begin @(negedge clk); n++; end
      chk("s4_latency", n, S4 + 2);
      chk("s4_result", res4, 0);
      chk("s4_mismatch", mis4, 1);
      chk("s4_rsp_op", rop4, 0);
      @(negedge clk);
      chk("s4_err_one", err4, 1);
      bad4 = 1'b0;
      v4 = 1'b1; a4 = 5'd9; b4 = 5'd9; op4 = 2'd2;
      @(negedge clk);
      v4 = 1'b0;
      @(negedge clk);
      chk("s4_in_drive", busy4, 1);
      chk("s4_no_rsp_yet", rv4, 0);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      chk("s4_rst_ready", rdy4, 1);
      chk("s4_rst_busy", busy4, 0);
      chk("s4_rst_valid", rv4, 0);
      chk("s4_rst_alu", {n1_4, n2_4, aop4}, 0);
      chk("s4_rst_err", err4, 0);
      repeat (6) @(negedge clk);
      chk("s4_rsp_discarded", rv4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
